// File: rtl/cv32e40p_ft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ft_pkg
// Description : Shared types and constants for the cv32e40p fault-tolerant
//               redundancy manager (mode / replica-state encodings, stats width).
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_ft_pkg;

    typedef enum logic [1:0] {
        FT_NORMAL   = 2'd0,
        FT_DEGRADED = 2'd1,
        FT_SIMPLEX  = 2'd2,
        FT_FAILED   = 2'd3
    } ft_mode_e;

    typedef enum logic [1:0] {
        REP_HEALTHY = 2'd0,
        REP_SUSPECT = 2'd1,
        REP_BROKEN  = 2'd2
    } ft_rep_state_e;

    localparam int unsigned FT_STATS_W = 16;

    // Map a count of healthy replicas onto the system operating mode.
    function automatic ft_mode_e ft_mode_from_count(input int unsigned healthy,
                                                    input int unsigned num_rep);
        ft_mode_e m;
        if (healthy >= num_rep) begin
            m = FT_NORMAL;
        end else if (healthy >= 2) begin
            m = FT_DEGRADED;
        end else if (healthy == 1) begin
            m = FT_SIMPLEX;
        end else begin
            m = FT_FAILED;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_ft_majority_vote.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ft_majority_vote
// Description : Combinational majority voter over the healthy subset of
//               NUM_REP replica words. Winner is the lowest-index healthy
//               replica whose value is shared by a strict majority of the
//               healthy set. Also reports which healthy replicas disagree.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_ft_majority_vote #(
    parameter int unsigned NUM_REP = 3,
    parameter int unsigned DATA_W  = 32,
    localparam int unsigned H_W    = $clog2(NUM_REP + 1)
) (
    input  logic [NUM_REP-1:0][DATA_W-1:0] data_i,
    input  logic [NUM_REP-1:0]             healthy_i,
    output logic                           winner_valid_o,
    output logic [DATA_W-1:0]              winner_data_o,
    output logic [NUM_REP-1:0]             mismatch_o,
    output logic [H_W-1:0]                 num_healthy_o
);

    logic [H_W-1:0] w_votes;

    // Count the healthy set, then pick the first replica holding a strict majority.
    always_comb begin
        num_healthy_o  = '0;
        winner_valid_o = 1'b0;
        winner_data_o  = '0;
        w_votes        = '0;
        for (int i = 0; i < NUM_REP; i++) begin
            if (healthy_i[i]) begin
                num_healthy_o = num_healthy_o + H_W'(1);
            end
        end
        for (int i = 0; i < NUM_REP; i++) begin
            w_votes = '0;
            for (int j = 0; j < NUM_REP; j++) begin
                if (healthy_i[j] && (data_i[j] == data_i[i])) begin
                    w_votes = w_votes + H_W'(1);
                end
            end
            if (!winner_valid_o && healthy_i[i] &&
                ({w_votes, 1'b0} > {1'b0, num_healthy_o})) begin
                winner_valid_o = 1'b1;
                winner_data_o  = data_i[i];
            end
        end
    end

    // Healthy replicas that disagree with the winner (meaningless without one).
    always_comb begin
        mismatch_o = '0;
        for (int i = 0; i < NUM_REP; i++) begin
            mismatch_o[i] = healthy_i[i] && winner_valid_o && (data_i[i] != winner_data_o);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cv32e40p_ft_redundancy_manager.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ft_redundancy_manager
// Description : N-way modular-redundancy voter with per-replica leaky mismatch
//               counters, replica retirement and operating-mode reporting.
//               Optional build macro CV32E40P_FT_VOTE_STATS_EN enables the
//               saturating no-majority event counter on vote_err_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_ft_redundancy_manager
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned NUM_REP    = 3,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ERR_THRESH = 3,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_i,
    input  logic [NUM_REP-1:0][DATA_W-1:0] data_i,
    input  logic [NUM_REP-1:0]             set_broken_i,
    input  logic                           clear_i,
    output logic                           valid_o,
    output logic [DATA_W-1:0]              data_o,
    output logic                           err_o,
    output logic [NUM_REP-1:0]             is_broken_o,
    output logic [1:0]                     mode_o,
    output logic [FT_STATS_W-1:0]          vote_err_cnt_o
);

    localparam int unsigned      H_W      = $clog2(NUM_REP + 1);
    localparam logic [CNT_W-1:0] C_CNTMAX = '1;
    localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(ERR_THRESH);

    logic [NUM_REP-1:0]             healthy;
    logic [NUM_REP-1:0]             broken_d;
    logic [NUM_REP-1:0]             mismatch;
    logic                           win_valid;
    logic [DATA_W-1:0]              win_data;
    logic [H_W-1:0]                 num_healthy;
    logic [H_W-1:0]                 num_healthy_d;
    logic                           cnt_upd;

    ft_rep_state_e [NUM_REP-1:0]    rep_state_q, rep_state_d;
    logic [NUM_REP-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    ft_mode_e                       mode_q, mode_d;
    logic                           valid_q, err_q;
    logic [DATA_W-1:0]              data_q;

    generate
        for (genvar k = 0; k < NUM_REP; k++) begin : g_flags
            assign healthy[k]  = (rep_state_q[k] != REP_BROKEN);
            assign broken_d[k] = (rep_state_d[k] == REP_BROKEN);
        end
    endgenerate

    cv32e40p_ft_majority_vote #(
        .NUM_REP (NUM_REP),
        .DATA_W  (DATA_W)
    ) u_vote (
        .data_i         (data_i),
        .healthy_i      (healthy),
        .winner_valid_o (win_valid),
        .winner_data_o  (win_data),
        .mismatch_o     (mismatch),
        .num_healthy_o  (num_healthy)
    );

    // Counters only learn from cycles where a genuine comparison was possible.
    assign cnt_upd = valid_i && win_valid && (num_healthy >= H_W'(2));

    // Per-replica leaky counter and HEALTHY/SUSPECT/BROKEN next state.
    always_comb begin
        cnt_d       = cnt_q;
        rep_state_d = rep_state_q;
        for (int k = 0; k < NUM_REP; k++) begin
            if (clear_i) begin
                // A same-cycle force beats the clear.
                cnt_d[k]       = '0;
                rep_state_d[k] = set_broken_i[k] ? REP_BROKEN : REP_HEALTHY;
            end else if (rep_state_q[k] != REP_BROKEN) begin
                if (cnt_upd) begin
                    if (mismatch[k]) begin
                        if (cnt_q[k] != C_CNTMAX) begin
                            cnt_d[k] = cnt_q[k] + CNT_W'(1);
                        end
                    end else if (cnt_q[k] != '0) begin
                        cnt_d[k] = cnt_q[k] - CNT_W'(1);
                    end
                end
                if (set_broken_i[k] || (cnt_upd && mismatch[k] && (cnt_d[k] >= C_THRESH))) begin
                    rep_state_d[k] = REP_BROKEN;
                end else if (cnt_d[k] == '0) begin
                    rep_state_d[k] = REP_HEALTHY;
                end else begin
                    rep_state_d[k] = REP_SUSPECT;
                end
            end
        end
    end

    // Operating mode follows the healthy count the flags will hold next cycle.
    always_comb begin
        num_healthy_d = '0;
        for (int k = 0; k < NUM_REP; k++) begin
            if (!broken_d[k]) begin
                num_healthy_d = num_healthy_d + H_W'(1);
            end
        end
        mode_d = ft_mode_from_count(32'(num_healthy_d), NUM_REP);
    end

    // Replica health and mode registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REP; k++) begin
                rep_state_q[k] <= REP_HEALTHY;
            end
            cnt_q  <= '0;
            mode_q <= FT_NORMAL;
        end else begin
            rep_state_q <= rep_state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
        end
    end

    // Voted output stage; data holds across invalid and no-majority cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                err_q <= !win_valid;
                if (win_valid) begin
                    data_q <= win_data;
                end
            end
        end
    end

`ifdef CV32E40P_FT_VOTE_STATS_EN
    logic [FT_STATS_W-1:0] stats_q;

    // Saturating count of valid cycles without a majority.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            stats_q <= '0;
        end else if (valid_i && !win_valid && (stats_q != '1)) begin
            stats_q <= stats_q + FT_STATS_W'(1);
        end
    end

    assign vote_err_cnt_o = stats_q;
`else
    assign vote_err_cnt_o = '0;
`endif

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign err_o       = err_q;
    assign is_broken_o = ~healthy;
    assign mode_o      = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_ft_redundancy_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_ft_redundancy_manager
// Description : Scoreboard testbench for the redundancy manager (3 replicas,
//               32-bit data, threshold 3). Directed vectors push expected
//               responses; a monitor pops and compares on each valid_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_ft_redundancy_manager;
    import cv32e40p_ft_pkg::*;

`ifdef CV32E40P_FT_VOTE_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             valid_i;
    logic [2:0][31:0] data_i;
    logic [2:0]       set_broken_i;
    logic             clear_i;
    logic             valid_o;
    logic [31:0]      data_o;
    logic             err_o;
    logic [2:0]       is_broken_o;
    logic [1:0]       mode_o;
    logic [15:0]      vote_err_cnt_o;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [2:0]  broken;
        logic [1:0]  mode;
        logic [15:0] stats;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    cv32e40p_ft_redundancy_manager #(
        .NUM_REP    (3),
        .DATA_W     (32),
        .ERR_THRESH (3),
        .CNT_W      (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .data_i         (data_i),
        .set_broken_i   (set_broken_i),
        .clear_i        (clear_i),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .err_o          (err_o),
        .is_broken_o    (is_broken_o),
        .mode_o         (mode_o),
        .vote_err_cnt_o (vote_err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // One input cycle; the expected response is queued when valid is driven.
    task automatic step(input logic v, input logic [31:0] d2, input logic [31:0] d1,
                        input logic [31:0] d0, input logic [2:0] sb, input logic clr,
                        input logic [31:0] ed, input logic ee, input logic [2:0] eb,
                        input ft_mode_e em, input logic [15:0] es);
        exp_t e;
        valid_i      = v;
        data_i       = {d2, d1, d0};
        set_broken_i = sb;
        clear_i      = clr;
        if (v) begin
            e.data   = ed;
            e.err    = ee;
            e.broken = eb;
            e.mode   = em;
            e.stats  = STATS_EN ? es : 16'h0000;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_i      = 1'b0;
        set_broken_i = 3'b000;
        clear_i      = 1'b0;
    endtask

    // Monitor: compare every presented output against the head of the queue.
    always @(negedge clk) begin
        if (valid_o) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: valid_o=1 with no queued response");
            end else begin
                m_e = sb_q.pop_front();
                chk("data_o",         data_o,                   m_e.data);
                chk("err_o",          32'(err_o),               32'(m_e.err));
                chk("is_broken_o",    32'(is_broken_o),         32'(m_e.broken));
                chk("mode_o",         32'(mode_o),              32'(m_e.mode));
                chk("vote_err_cnt_o", 32'(vote_err_cnt_o),      32'(m_e.stats));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        valid_i      = 1'b0;
        data_i       = '0;
        set_broken_i = 3'b000;
        clear_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_o",  32'(valid_o),        32'h0);
        chk("rst_data_o",   data_o,              32'h0);
        chk("rst_err_o",    32'(err_o),          32'h0);
        chk("rst_broken",   32'(is_broken_o),    32'h0);
        chk("rst_mode",     32'(mode_o),         32'(FT_NORMAL));
        chk("rst_stats",    32'(vote_err_cnt_o), 32'h0);
        rst = 1'b0;

        // Unanimous vote.
        step(1, 5, 5, 5, 3'b000, 0,  5, 0, 3'b000, FT_NORMAL,   0);
        // Replica 2 disagrees three times in a row -> retired.
        step(1, 1, 0, 0, 3'b000, 0,  0, 0, 3'b000, FT_NORMAL,   0);
        step(1, 1, 0, 0, 3'b000, 0,  0, 0, 3'b000, FT_NORMAL,   0);
        step(1, 1, 0, 0, 3'b000, 0,  0, 0, 3'b100, FT_DEGRADED, 0);
        // Two healthy replicas: both must agree.
        step(1, 0, 7, 7, 3'b000, 0,  7, 0, 3'b100, FT_DEGRADED, 0);
        step(1, 0, 7, 6, 3'b000, 0,  7, 1, 3'b100, FT_DEGRADED, 1);
        // Clear while voting; vote still uses the pre-clear healthy set.
        step(1, 9, 9, 9, 3'b000, 1,  9, 0, 3'b000, FT_NORMAL,   0);
        // Leaky decay: counter 1,0,0,1,2,1 never reaches the threshold.
        step(1, 1, 0, 0, 3'b000, 0,  0, 0, 3'b000, FT_NORMAL,   0);
        step(1, 0, 0, 0, 3'b000, 0,  0, 0, 3'b000, FT_NORMAL,   0);
        step(1, 0, 0, 0, 3'b000, 0,  0, 0, 3'b000, FT_NORMAL,   0);
        step(1, 1, 0, 0, 3'b000, 0,  0, 0, 3'b000, FT_NORMAL,   0);
        step(1, 1, 0, 0, 3'b000, 0,  0, 0, 3'b000, FT_NORMAL,   0);
        step(1, 0, 0, 0, 3'b000, 0,  0, 0, 3'b000, FT_NORMAL,   0);
        step(0, 0, 0, 0, 3'b000, 1,  0, 0, 3'b000, FT_NORMAL,   0);
        // Forced retirement down to simplex, then to failed.
        step(0, 0, 0, 0, 3'b011, 0,  0, 0, 3'b000, FT_NORMAL,   0);
        step(1, 4, 2, 3, 3'b000, 0,  4, 0, 3'b011, FT_SIMPLEX,  0);
        step(0, 0, 0, 0, 3'b100, 0,  0, 0, 3'b000, FT_NORMAL,   0);
        step(1, 5, 5, 5, 3'b000, 0,  4, 1, 3'b111, FT_FAILED,   1);
        // Clear with a same-cycle force on replica 0: force wins.
        step(0, 0, 0, 0, 3'b001, 1,  0, 0, 3'b000, FT_NORMAL,   0);
        step(1, 8, 8, 8, 3'b000, 0,  8, 0, 3'b001, FT_DEGRADED, 0);
        // No-majority run on the two remaining replicas.
        step(1, 1, 2, 3, 3'b000, 0,  8, 1, 3'b001, FT_DEGRADED, 1);
        step(1, 1, 2, 3, 3'b000, 0,  8, 1, 3'b001, FT_DEGRADED, 2);
        step(1, 1, 2, 3, 3'b000, 0,  8, 1, 3'b001, FT_DEGRADED, 3);
        step(1, 1, 2, 3, 3'b000, 0,  8, 1, 3'b001, FT_DEGRADED, 4);
        step(0, 0, 0, 0, 3'b000, 1,  0, 0, 3'b000, FT_NORMAL,   0);
        step(1, 3, 3, 3, 3'b000, 0,  3, 0, 3'b000, FT_NORMAL,   0);
        step(0, 0, 0, 0, 3'b010, 0,  0, 0, 3'b000, FT_NORMAL,   0);

        // Reset mid-operation with a valid input in flight.
        rst          = 1'b1;
        valid_i      = 1'b1;
        data_i       = {32'd6, 32'd6, 32'd6};
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        chk("midrst_valid_o", 32'(valid_o),        32'h0);
        chk("midrst_data_o",  data_o,              32'h0);
        chk("midrst_err_o",   32'(err_o),          32'h0);
        chk("midrst_broken",  32'(is_broken_o),    32'h0);
        chk("midrst_mode",    32'(mode_o),         32'(FT_NORMAL));
        chk("midrst_stats",   32'(vote_err_cnt_o), 32'h0);
        rst = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
